// File: rtl/row_fifo_reader.sv
// row_fifo_reader: drains Wh parallel row FIFOs in fixed-length row bursts onto a valid/ready stream.
// Optional macro ROW_READER_ZERO_PAD_EN appends PAD_ROWS all-zero rows to every frame.
module row_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int Wh         = 3,
  parameter int Iw         = 7,
  parameter int BURST_LEN  = 16,
  parameter int ROW_COUNT  = 50,
  parameter int PAD_ROWS   = 4,
  parameter int ROW_WIDTH  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Wh-1:0]              fifo_prog_empty,
  output logic [Wh-1:0]              fifo_rden,
  input  logic [Wh*Iw*DATA_WIDTH-1:0] fifo_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Wh*Iw*DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic [ROW_WIDTH-1:0]       row_idx,
  output logic                       busy,
  output logic                       frame_done
);

  // state | meaning
  // IDLE  | waiting for start
  // WAIT  | row pending, waiting for every FIFO above prog-empty
  // BURST | issuing BURST_LEN reads (or zero words on a pad row)
  // DRAIN | reads done, emptying in-flight word and skid buffer
  // GAP   | two idle cycles between rows
  // DONE  | frame complete, frame_done pulse

  localparam int WORD_W = Wh * Iw * DATA_WIDTH;
`ifdef ROW_READER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int TOTAL_ROWS = ROW_COUNT + (PAD_EN ? PAD_ROWS : 0);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [ROW_WIDTH-1:0] BURST_LD = ROW_WIDTH'(BURST_LEN);
  localparam logic [ROW_WIDTH-1:0] ONE      = ROW_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN, S_GAP, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ROW_WIDTH-1:0] burst_rem_q, burst_rem_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic                 gap_cnt_q, gap_cnt_d;
  logic                 fly_q, fly_d, fly_last_q, fly_last_d, fly_pad_q, fly_pad_d;
  logic                 v0_q, v0_d, v1_q, v1_d, l0_q, l0_d, l1_q, l1_d;
  logic [WORD_W-1:0]    d0_q, d0_d, d1_q, d1_d;

  logic              pad_row, next_pad, issue, push, pop;
  logic [1:0]        pending;
  logic [WORD_W-1:0] push_data;

  assign pad_row  = PAD_EN && (row_q >= ROW_WIDTH'(ROW_COUNT));
  assign next_pad = PAD_EN && (row_q >= ROW_WIDTH'(ROW_COUNT - 1));
  assign pop      = v0_q & out_ready;
  assign pending  = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, fly_q};
  // A pop in the same cycle frees a slot, so reads keep going at full rate under ready.
  assign issue    = (state_q == S_BURST) && (burst_rem_q != '0) && ((pending < 2'd2) || pop);
  assign push      = fly_q;
  assign push_data = fly_pad_q ? '0 : fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (~|fifo_prog_empty) state_d = S_BURST;
      S_BURST: if (issue && burst_rem_q == ONE) state_d = S_DRAIN;
      S_DRAIN: if (!v0_q && !v1_q && !fly_q) state_d = S_GAP;
      S_GAP:   if (gap_cnt_q == 1'b0) begin
                 if (row_q == LAST_ROW) state_d = S_DONE;
                 else if (next_pad)     state_d = S_BURST;
                 else                   state_d = S_WAIT;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rden  = {Wh{issue & ~pad_row}};
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    out_valid  = v0_q;
    out_data   = d0_q;
    out_last   = v0_q & l0_q;
    row_idx    = row_q;
  end

  always_comb begin
    burst_rem_d = burst_rem_q;
    gap_cnt_d   = gap_cnt_q;
    row_d       = row_q;
    if (state_d == S_BURST && state_q != S_BURST) burst_rem_d = BURST_LD;
    else if (issue)                               burst_rem_d = burst_rem_q - ONE;
    if (state_d == S_GAP && state_q != S_GAP) gap_cnt_d = 1'b1;
    else if (state_q == S_GAP)                gap_cnt_d = 1'b0;
    if (state_q == S_GAP && gap_cnt_q == 1'b0)
      row_d = (row_q == LAST_ROW) ? '0 : row_q + ONE;
    fly_d      = issue;
    fly_last_d = issue && (burst_rem_q == ONE);
    fly_pad_d  = issue && pad_row;
  end

  // Two-entry skid: entry 0 is always the head presented downstream.
  always_comb begin
    v0_d = v0_q; v1_d = v1_q; l0_d = l0_q; l1_d = l1_q; d0_d = d0_q; d1_d = d1_q;
    case ({push, pop})
      2'b10: begin
        if (!v0_q) begin v0_d = 1'b1; d0_d = push_data; l0_d = fly_last_q; end
        else       begin v1_d = 1'b1; d1_d = push_data; l1_d = fly_last_q; end
      end
      2'b01: begin
        v0_d = v1_q; d0_d = d1_q; l0_d = l1_q & v1_q; v1_d = 1'b0; l1_d = 1'b0;
      end
      2'b11: begin
        if (v1_q) begin
          d0_d = d1_q; l0_d = l1_q; d1_d = push_data; l1_d = fly_last_q;
        end else begin
          d0_d = push_data; l0_d = fly_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_rem_q <= '0;
      gap_cnt_q   <= 1'b0;
      row_q       <= '0;
      fly_q       <= 1'b0;
      fly_last_q  <= 1'b0;
      fly_pad_q   <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
    end else begin
      burst_rem_q <= burst_rem_d;
      gap_cnt_q   <= gap_cnt_d;
      row_q       <= row_d;
      fly_q       <= fly_d;
      fly_last_q  <= fly_last_d;
      fly_pad_q   <= fly_pad_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
    end
  end

endmodule

// File: tb/tb_row_fifo_reader.sv
// Directed bench for row_fifo_reader: FIFO bank model, frame runs under several ready/prog-empty patterns.
// Expectations follow ROW_READER_ZERO_PAD_EN when the bench is built with it.
module tb_row_fifo_reader;
  localparam int DW = 8, WH = 3, IW = 7, BL = 16, RC = 2, PR = 1, RW = 10;
  localparam int W = WH * IW * DW;
`ifdef ROW_READER_ZERO_PAD_EN
  localparam int ROWS = RC + PR;
`else
  localparam int ROWS = RC;
`endif

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [WH-1:0] prog_empty, rden;
  logic [W-1:0]  dout, out_data;
  logic          out_valid, out_last, busy, frame_done;
  logic [RW-1:0] row_idx;

  int n_cmp = 0, n_bad = 0;
  int rd_ptr = 0;
  int rel = 0;
  int rden_cnt, acc_real, words_out, done_cnt, first_rd, last_rd0, first_vld, base_ptr;

  row_fifo_reader #(
    .DATA_WIDTH(DW), .Wh(WH), .Iw(IW), .BURST_LEN(BL),
    .ROW_COUNT(RC), .PAD_ROWS(PR), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fifo_prog_empty(prog_empty),
    .fifo_rden(rden), .fifo_dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .row_idx(row_idx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gen_word(input int k);
    logic [W-1:0] w;
    for (int j = 0; j < WH * IW; j++) w[j*DW +: DW] = DW'(k * 21 + j * 3 + 1);
    return w;
  endfunction

  // FIFO bank: one-cycle read latency, contents persist across DUT reset.
  always @(posedge clk) begin
    if (rden[0]) begin
      dout   <= gen_word(rd_ptr);
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_begin();
    rden_cnt = 0; acc_real = 0; words_out = 0; done_cnt = 0; rel = 0;
    first_rd = -1; last_rd0 = -1; first_vld = -1; base_ptr = rd_ptr;
  endtask

  task automatic cycle(input logic rdy, input logic st, input logic [WH-1:0] pe);
    logic pop;
    int   j;
    @(negedge clk);
    out_ready = rdy; start = st; prog_empty = pe;
    #1;
    pop = out_valid & rdy;
    if (rden != '0) begin
      chki("rden_uniform", int'(rden), (1 << WH) - 1);
      chki("rden_pending", int'(((rden_cnt - acc_real) < 2) || pop), 1);
      chki("rden_overread", int'(rden_cnt < RC * BL), 1);
      if (rden_cnt == 0) first_rd = rel;
      if (rden_cnt == BL - 1) last_rd0 = rel;
      rden_cnt++;
    end
    if (pop) begin
      j = words_out;
      if (j == 0) first_vld = rel;
      chkw("data", out_data, (j / BL < RC) ? gen_word(base_ptr + j) : '0);
      chki("last", int'(out_last), int'((j % BL) == BL - 1));
      chki("row_idx", int'(row_idx), j / BL);
      if (j / BL < RC) acc_real++;
      words_out++;
    end
    if (frame_done) done_cnt++;
    rel++;
  endtask

  // mode 0: ready high; 1: FIFO 2 prog-empty held 30 cycles; 2: ready toggles; 3: start re-pulsed mid-burst
  task automatic run_frame(input int mode);
    logic          rdy, st;
    logic [WH-1:0] pe;
    frame_begin();
    cycle(1'b1, 1'b1, (mode == 1) ? 3'b100 : 3'b000);
    while (done_cnt == 0 && rel < 800) begin
      rdy = (mode == 2) ? ((rel % 2) == 1) : 1'b1;
      st  = (mode == 3) && (rel == 6);
      pe  = '0;
      if (mode == 1 && rel <= 30) pe = 3'b100;
      if (mode == 3 && rel >= 5 && rel <= 10) pe = 3'b001;
      cycle(rdy, st, pe);
      if (mode == 1 && rel <= 31) chki("rden_hold", int'(rden), 0);
    end
    repeat (4) cycle(1'b1, 1'b0, '0);
    chki("frame_words", words_out, ROWS * BL);
    chki("frame_rdens", rden_cnt, RC * BL);
    chki("frame_done_once", done_cnt, 1);
    chki("busy_after", int'(busy), 0);
    chki("row_wrap", int'(row_idx), 0);
    if (mode != 2) chki("row0_unbroken", last_rd0 - first_rd, BL - 1);
    if (mode == 0) begin
      chki("lat_rden", first_rd, 2);
      chki("lat_valid", first_vld - first_rd, 2);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chki({tag, "_rden"}, int'(rden), 0);
    chki({tag, "_valid"}, int'(out_valid), 0);
    chki({tag, "_last"}, int'(out_last), 0);
    chki({tag, "_row"}, int'(row_idx), 0);
    chki({tag, "_busy"}, int'(busy), 0);
    chki({tag, "_done"}, int'(frame_done), 0);
    chkw({tag, "_data"}, out_data, '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_empty = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_quiet("reset");
    @(negedge clk) rst = 1'b0;
    cycle(1'b1, 1'b0, '0);
    chki("idle_busy", int'(busy), 0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);

    frame_begin();
    cycle(1'b1, 1'b1, '0);
    while (words_out < 5 && rel < 200) cycle(1'b1, 1'b0, '0);
    chki("rst_at_word5", words_out, 5);
    @(negedge clk) rst = 1'b1;
    #1 chk_quiet("midrst");
    @(negedge clk);
    #1 chk_quiet("midrst_hold");
    @(negedge clk) rst = 1'b0;
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
